// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (clk/reset in; hsync, vsync, video_on, pixel_tick, pixel_x, pixel_y, frame_start out)
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic pixel_tick_q, pixel_tick_d, frame_start_q, frame_start_d;
  logic tick, h_wrap;
  always_comb begin
    tick = div_cnt_q == DIV_LAST;
    h_wrap = tick && h_cnt_q == H_LAST;
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d = !tick ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = !h_wrap ? v_cnt_q : v_cnt_q == V_LAST ? '0 : v_cnt_q + 10'd1;
    video_on_d = h_cnt_d < H_VIS && v_cnt_d < V_VIS;
    hsync_d = (h_cnt_d >= HS_BEG && h_cnt_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_cnt_d >= VS_BEG && v_cnt_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    pixel_tick_d = tick;
    frame_start_d = h_wrap && v_cnt_q == V_LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_on_q <= 1'b0;
      pixel_tick_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_on_q <= video_on_d;
      pixel_tick_q <= pixel_tick_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign video_on = video_on_q;
  assign pixel_tick = pixel_tick_q;
  assign pixel_x = h_cnt_q;
  assign pixel_y = v_cnt_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for three vga_sync_gen configurations against an arithmetic raster model
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  typedef struct packed {
    logic hs, vs, vo, tk, fs;
    logic [9:0] x, y;
  } vec_t;
  logic hs [3], vs [3], vo [3], tk [3], fs [3];
  logic [9:0] px [3], py [3];
  vec_t q0 [$], q1 [$], q2 [$];
  int vectors = 0;
  int miscompares = 0;
  vga_sync_gen u_big (
    .clk(clk), .reset(reset), .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
    .pixel_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]), .frame_start(fs[0])
  );
  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
    .pixel_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]), .frame_start(fs[1])
  );
  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset(reset), .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]),
    .pixel_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]), .frame_start(fs[2])
  );
  // k = clks since the last clk edge that sampled reset (0 = in reset)
  function automatic vec_t model(int k, int d, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, bit pol);
    vec_t e;
    int ht, vt, pos, x, y;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    if (k == 0) begin
      e.hs = ~pol; e.vs = ~pol; e.vo = 1'b0; e.tk = 1'b0; e.fs = 1'b0;
      e.x = '0; e.y = '0;
      return e;
    end
    pos = (k / d) % (ht * vt);
    x = pos % ht;
    y = pos / ht;
    e.x = 10'(x);
    e.y = 10'(y);
    e.vo = x < hd && y < vd;
    e.hs = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
    e.vs = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
    e.tk = (k % d) == 0;
    e.fs = e.tk && pos == 0;
    return e;
  endfunction
  task automatic check(input string name, input vec_t got, input vec_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got hs=%b vs=%b vo=%b tk=%b fs=%b x=%0d y=%0d want hs=%b vs=%b vo=%b tk=%b fs=%b x=%0d y=%0d",
               name, got.hs, got.vs, got.vo, got.tk, got.fs, got.x, got.y,
               want.hs, want.vs, want.vo, want.tk, want.fs, want.x, want.y);
    end
  endtask
  function automatic vec_t grab(int i);
    vec_t v;
    v.hs = hs[i]; v.vs = vs[i]; v.vo = vo[i]; v.tk = tk[i]; v.fs = fs[i];
    v.x = px[i]; v.y = py[i];
    return v;
  endfunction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) check("big", grab(0), q0.pop_front());
      if (q1.size() != 0) check("small", grab(1), q1.pop_front());
      if (q2.size() != 0) check("pol", grab(2), q2.pop_front());
    end
  end
  initial begin
    int k = 0;
    int rst_left = 3;
    for (int c = 0; c < 25000; c++) begin
      @(negedge clk);
      if (rst_left == 0 && c > 8000 && $urandom_range(0, 2999) == 0)
        rst_left = $urandom_range(1, 3);
      reset = rst_left > 0;
      if (rst_left > 0) rst_left--;
      k = reset ? 0 : k + 1;
      q0.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      q1.push_back(model(k, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0));
      q2.push_back(model(k, 3, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
    end
    @(posedge clk);
    #2;
    vectors++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
